// File: rtl/mod_inv_seq_pkg.sv
// rtl/mod_inv_seq_pkg.sv - shared FSM encoding and derived widths for the modular-inverse engine
package mod_inv_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Signed Bezout coefficient width: one sign bit over the operand width.
   function automatic int t_width(input int w);
      return w + 1;
   endfunction

   function automatic int prod_width(input int w);
      return 2 * w + 2;
   endfunction

   function automatic int cnt_width(input int w);
      return $clog2(2 * w + 2);
   endfunction

endpackage

// File: rtl/mod_inv_seq_euclid_step.sv
// rtl/mod_inv_seq_euclid_step.sv - one combinational extended-Euclid quotient/remainder step
module euclid_step
   import mod_inv_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic        [WIDTH-1:0] r_prev,
   input  logic        [WIDTH-1:0] r_cur,
   input  logic signed [WIDTH:0]   t_prev,
   input  logic signed [WIDTH:0]   t_cur,
   output logic        [WIDTH-1:0] r_new,
   output logic signed [WIDTH:0]   t_new
);

   localparam int TW = t_width(WIDTH);
   localparam int PW = prod_width(WIDTH);

   logic        [WIDTH-1:0] divisor;
   logic        [WIDTH-1:0] q;
   logic signed [PW-1:0]    q_ext;
   logic signed [PW-1:0]    t_cur_ext;
   logic signed [PW-1:0]    t_prev_ext;
   logic signed [PW-1:0]    prod;

   always_comb begin
      // The caller never consumes the result when r_cur is zero; the mux only keeps the divider defined.
      divisor    = (r_cur == '0) ? WIDTH'(1) : r_cur;
      q          = r_prev / divisor;
      r_new      = r_prev - q * divisor;
      q_ext      = signed'({{(PW-WIDTH){1'b0}}, q});
      t_cur_ext  = signed'({{(PW-TW){t_cur[TW-1]}}, t_cur});
      t_prev_ext = signed'({{(PW-TW){t_prev[TW-1]}}, t_prev});
      prod       = q_ext * t_cur_ext;
      t_new      = TW'(t_prev_ext - prod);
   end

endmodule

// File: rtl/mod_inv_seq.sv
// rtl/mod_inv_seq.sv - handshaked iterative modular inverse, one Euclid step per clock
module mod_inv_seq
   import mod_inv_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_inv,
   output logic [WIDTH-1:0] out_gcd,
   output logic             out_err
);

   localparam int TW    = t_width(WIDTH);
   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(2 * WIDTH + 1);

   state_e                  state_q, state_d;
   logic        [WIDTH-1:0] m_q, m_d;
   logic        [WIDTH-1:0] r_prev_q, r_prev_d;
   logic        [WIDTH-1:0] r_cur_q, r_cur_d;
   logic signed [TW-1:0]    t_prev_q, t_prev_d;
   logic signed [TW-1:0]    t_cur_q, t_cur_d;
   logic        [CNT_W-1:0] step_q, step_d;
   logic                    out_valid_q, out_valid_d;
   logic        [WIDTH-1:0] out_inv_q, out_inv_d;
   logic        [WIDTH-1:0] out_gcd_q, out_gcd_d;
   logic                    out_err_q, out_err_d;

   logic        [WIDTH-1:0] r_new;
   logic signed [TW-1:0]    t_new;
   logic                    err_now;

   euclid_step #(.WIDTH(WIDTH)) u_step (
      .r_prev (r_prev_q),
      .r_cur  (r_cur_q),
      .t_prev (t_prev_q),
      .t_cur  (t_cur_q),
      .r_new  (r_new),
      .t_new  (t_new)
   );

   always_comb begin
      state_d     = state_q;
      m_d         = m_q;
      r_prev_d    = r_prev_q;
      r_cur_d     = r_cur_q;
      t_prev_d    = t_prev_q;
      t_cur_d     = t_cur_q;
      step_d      = step_q;
      out_valid_d = out_valid_q;
      out_inv_d   = out_inv_q;
      out_gcd_d   = out_gcd_q;
      out_err_d   = out_err_q;
      err_now     = (r_prev_q != WIDTH'(1)) || (m_q < WIDTH'(2));

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               m_d      = (in_a >= in_b) ? in_a : in_b;
               r_prev_d = (in_a >= in_b) ? in_a : in_b;
               r_cur_d  = (in_a >= in_b) ? in_b : in_a;
               t_prev_d = '0;
               t_cur_d  = TW'(1);
               step_d   = '0;
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            // The step limit is unreachable for legal operands; it only bounds the loop.
            if ((r_cur_q == '0) || (step_q == STEP_MAX)) begin
               out_gcd_d   = r_prev_q;
               out_err_d   = err_now;
               if (err_now) begin
                  out_inv_d = '0;
               end else if (t_prev_q[TW-1]) begin
                  out_inv_d = WIDTH'(t_prev_q + signed'({1'b0, m_q}));
               end else begin
                  out_inv_d = t_prev_q[WIDTH-1:0];
               end
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               r_prev_d = r_cur_q;
               r_cur_d  = r_new;
               t_prev_d = t_cur_q;
               t_cur_d  = t_new;
               step_d   = step_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         m_q         <= '0;
         r_prev_q    <= '0;
         r_cur_q     <= '0;
         t_prev_q    <= '0;
         t_cur_q     <= '0;
         step_q      <= '0;
         out_valid_q <= 1'b0;
         out_inv_q   <= '0;
         out_gcd_q   <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         m_q         <= m_d;
         r_prev_q    <= r_prev_d;
         r_cur_q     <= r_cur_d;
         t_prev_q    <= t_prev_d;
         t_cur_q     <= t_cur_d;
         step_q      <= step_d;
         out_valid_q <= out_valid_d;
         out_inv_q   <= out_inv_d;
         out_gcd_q   <= out_gcd_d;
         out_err_q   <= out_err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_inv   = out_inv_q;
   assign out_gcd   = out_gcd_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_mod_inv_seq.sv
// tb/tb_mod_inv_seq.sv - directed and random self-checking bench for mod_inv_seq
module tb_mod_inv_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_inv;
   logic [W-1:0] out_gcd;
   logic         out_err;

   mod_inv_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inv   (out_inv),
      .out_gcd   (out_gcd),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           inv;
      int           gcd;
      int           err;
      int           lat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Presents one operand pair and returns the cycle distance to out_valid, or -1 on timeout.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      int c0;
      int n;
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      c0       = cyc;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 64) begin
         @(negedge clk);
         n++;
      end
      lat = out_valid ? (cyc - c0) : -1;
   endtask

   function automatic void ref_model(input int a, input int b, output int inv,
                                     output int gcd, output int err, output int k);
      int m, x, rp, rc, tmp;
      m = (a >= b) ? a : b;
      x = (a >= b) ? b : a;
      rp = m;
      rc = x;
      k = 0;
      while (rc != 0) begin
         tmp = rp % rc;
         rp  = rc;
         rc  = tmp;
         k++;
      end
      gcd = rp;
      err = (gcd != 1 || m < 2) ? 1 : 0;
      inv = 0;
      if (err == 0) begin
         for (int i = 1; i < m; i++) begin
            if ((x * i) % m == 1 && inv == 0) inv = i;
         end
      end
   endfunction

   initial begin
      int lat;
      int seen;
      int e_inv, e_gcd, e_err, e_k;
      logic [W-1:0] ra, rb;

      vecs[0]  = '{a: 8'd7,   b: 8'd3,   inv: 5,   gcd: 1,   err: 0, lat: 4};
      vecs[1]  = '{a: 8'd233, b: 8'd144, inv: 89,  gcd: 1,   err: 0, lat: 13};
      vecs[2]  = '{a: 8'd6,   b: 8'd4,   inv: 0,   gcd: 2,   err: 1, lat: 4};
      vecs[3]  = '{a: 8'd0,   b: 8'd5,   inv: 0,   gcd: 5,   err: 1, lat: 2};
      vecs[4]  = '{a: 8'd5,   b: 8'd5,   inv: 0,   gcd: 5,   err: 1, lat: 3};
      vecs[5]  = '{a: 8'd254, b: 8'd255, inv: 254, gcd: 1,   err: 0, lat: 4};
      vecs[6]  = '{a: 8'd1,   b: 8'd1,   inv: 0,   gcd: 1,   err: 1, lat: 3};
      vecs[7]  = '{a: 8'd0,   b: 8'd0,   inv: 0,   gcd: 0,   err: 1, lat: 2};
      vecs[8]  = '{a: 8'd1,   b: 8'd0,   inv: 0,   gcd: 1,   err: 1, lat: 2};
      vecs[9]  = '{a: 8'd3,   b: 8'd10,  inv: 7,   gcd: 1,   err: 0, lat: 4};
      vecs[10] = '{a: 8'd2,   b: 8'd1,   inv: 1,   gcd: 1,   err: 0, lat: 3};

      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_inv", int'(out_inv), 0);
      check("rst_out_gcd", int'(out_gcd), 0);
      check("rst_out_err", int'(out_err), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
         check($sformatf("v%0d_inv", i), int'(out_inv), vecs[i].inv);
         check($sformatf("v%0d_gcd", i), int'(out_gcd), vecs[i].gcd);
         check($sformatf("v%0d_err", i), int'(out_err), vecs[i].err);
         @(negedge clk);
         check($sformatf("v%0d_ready_after", i), int'(in_ready), 1);
         check($sformatf("v%0d_valid_after", i), int'(out_valid), 0);
      end

      // Backpressure: result held, engine busy, extra in_valid ignored.
      out_ready = 1'b0;
      run_op(8'd254, 8'd255, lat);
      check("hold_lat", lat, 4);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            in_a     = 8'd3;
            in_b     = 8'd7;
            in_valid = 1'b1;
         end
         if (i == 2) in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("hold%0d_valid", i), int'(out_valid), 1);
         check($sformatf("hold%0d_ready", i), int'(in_ready), 0);
         check($sformatf("hold%0d_inv", i), int'(out_inv), 254);
         check($sformatf("hold%0d_gcd", i), int'(out_gcd), 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_ready", int'(in_ready), 1);
      check("release_valid", int'(out_valid), 0);
      check("release_inv_kept", int'(out_inv), 254);
      repeat (2) @(negedge clk);
      check("ignored_ready", int'(in_ready), 1);
      check("ignored_valid", int'(out_valid), 0);

      // Asynchronous reset in the middle of a long computation.
      in_a     = 8'd233;
      in_b     = 8'd144;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", int'(in_ready), 1);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_inv", int'(out_inv), 0);
      check("mid_rst_gcd", int'(out_gcd), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mid_rst_no_result", seen, 0);
      run_op(8'd7, 8'd3, lat);
      check("post_rst_lat", lat, 4);
      check("post_rst_inv", int'(out_inv), 5);
      check("post_rst_err", int'(out_err), 0);

      for (int i = 0; i < 300; i++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         ref_model(int'(ra), int'(rb), e_inv, e_gcd, e_err, e_k);
         run_op(ra, rb, lat);
         check($sformatf("rnd%0d_lat a=%0d b=%0d", i, ra, rb), lat, e_k + 2);
         check($sformatf("rnd%0d_inv a=%0d b=%0d", i, ra, rb), int'(out_inv), e_inv);
         check($sformatf("rnd%0d_gcd a=%0d b=%0d", i, ra, rb), int'(out_gcd), e_gcd);
         check($sformatf("rnd%0d_err a=%0d b=%0d", i, ra, rb), int'(out_err), e_err);
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_inv_seq.md
Name: mod_inv_seq

Overview:
Iterative modular-inverse engine, parametrised in operand width. Takes two unsigned operands and sets m = max, x = min. Runs the extended Euclidean algorithm, one quotient/remainder step per clock, and returns x^-1 mod m, gcd(x, m) and an error flag. It is the multi-cycle, handshaked successor of the single-cycle combinational inverse IP, for widths where a fully unrolled divider chain does not meet timing.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..16
CNT_W, $clog2(2*WIDTH+2), width of the internal step counter; derived, not overridden

Ports:
clk        input   1        clock, all state on rising edge
rst_n      input   1        asynchronous active-low reset
in_valid   input   1        operand pair valid
in_ready   output  1        engine idle, can accept operands
in_a       input   WIDTH    operand A, unsigned
in_b       input   WIDTH    operand B, unsigned
out_valid  output  1        result valid, held until out_ready
out_ready  input   1        downstream accepts result
out_inv    output  WIDTH    x^-1 mod m in [1, m-1]; 0 when out_err
out_gcd    output  WIDTH    gcd(x, m)
out_err    output  1        no inverse: gcd != 1, or x == 0, or m < 2

Behaviour:
- Reset (async, rst_n low): state IDLE. in_ready=1, out_valid=0, out_inv=0, out_gcd=0, out_err=0, all datapath registers 0.
- Reset mid-CALC or mid-DONE aborts immediately. Any result in flight is lost and no out_valid is produced.
- FSM IDLE -> CALC -> DONE -> IDLE.
- in_ready = (state==IDLE). The only handshake is on a rising edge with in_valid && in_ready. in_valid outside IDLE is ignored.
- On accept: m = max(A,B), x = min(A,B).
  - Load r_prev=m, r_cur=x, t_prev=0, t_cur=1, step=0.
  - Next state CALC.
- t registers are signed WIDTH+1 bits. |t| <= m is guaranteed, so no overflow.
- q*t_cur is formed at full 2*WIDTH+2 width before the subtract.
- CALC, if r_cur != 0: one step per cycle.
  - q = r_prev / r_cur, r_new = r_prev - q*r_cur, t_new = t_prev - q*t_cur.
  - Then (r_prev,r_cur) <= (r_cur,r_new), (t_prev,t_cur) <= (t_cur,t_new), step+1.
- CALC, if r_cur == 0: terminate.
  - out_gcd <= r_prev.
  - out_err <= (r_prev != 1) || (m < 2). This covers x == 0 and x == m.
  - out_inv <= err ? 0 : (t_prev < 0 ? t_prev + m : t_prev).
  - out_valid <= 1, state DONE.
- Latency: handshake at edge T, k Euclid steps. CALC occupies cycles T+1 .. T+k+1, and out_valid is high from cycle T+k+2.
  - k = 0 when x == 0.
  - k <= 1.44*WIDTH+2, and the step counter must never wrap for any legal WIDTH.
- DONE: outputs held stable while out_ready=0. On out_ready=1 at an edge: out_valid <= 0, state IDLE, in_ready=1 the following cycle. Outputs other than out_valid keep their last value.
- No back-to-back accept in the DONE cycle. Minimum spacing between accepts is k+3 cycles.
- A==B: m = x, one step, gcd = m, err=1.

Decomposition:
- Shared package/header: FSM state encodings (IDLE, CALC, DONE) and the derived width constants (WIDTH+1 signed t width, product width, CNT_W).
- One sub-module, euclid_step (combinational).
  - Inputs: r_prev, r_cur, t_prev, t_cur.
  - Outputs: r_new, t_new.
  - Instantiated once in the CALC datapath. The top holds only the FSM, registers and output formatting.

Test Plan:
1. WIDTH=8, A=7, B=3, out_ready=1 -> k=2. out_valid at T+4 with inv=5, gcd=1, err=0. Check 3*5 mod 7 = 1.
2. WIDTH=8, A=233, B=144 (Fibonacci worst case) -> k=11. out_valid at T+13 with inv=89, gcd=1, err=0.
3. WIDTH=8, A=6, B=4 -> inv=0, gcd=2, err=1. Also A=0, B=5 -> k=0, out_valid at T+2, gcd=5, err=1. Also A=B=5 -> gcd=5, err=1.
4. WIDTH=8, A=254, B=255 (operand order swapped) -> inv=254, gcd=1.
   - Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, a new in_valid pulse is ignored.
   - Release out_ready: in_ready=1 on the next cycle.
5. Reset mid-CALC of case 2 (rst_n low at T+6) -> outputs 0, in_ready=1 immediately, no out_valid.
   - Then issue A=7, B=3: result 5 with correct latency.
6. Random sweep for WIDTH=5, 8, 12: 10k pairs against a reference model.
   - When err=0, check x*inv mod m == 1 and inv in [1, m-1].
   - When err=1, check gcd != 1, x == 0 or m < 2.
   - Check latency == k+2 cycles.
